bpd_stage1_param: RTL and testbench

BPD_STAGE1_PARAM -- requirements
Module: bpd_stage1_param

---
 rtl/bpd_stage1_param.sv | 156 +++++++++++++++
 tb/tb_bpd_stage1_param.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bpd_stage1_param.sv
// First stage of a tournament predictor: per-PC local history table plus choice counters,
// swept to known values after reset, read combinationally and captured into f1 registers.
module bpd_stage1_param #(
  parameter int                      BHT_ENTRIES   = 1024,
  parameter int                      HIST_WIDTH    = 10,
  parameter int                      CH_ENTRIES    = 4096,
  parameter int                      SATCNT_WIDTH  = 2,
  parameter logic [SATCNT_WIDTH-1:0] SATCNT_INIT   = 2'b10,
  parameter int                      GHR_WIDTH     = 12,
  parameter int                      CH_INDEX_MODE = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load_fetch_i,
  input  logic [63:0]           sp_pc_i,
  input  logic [63:0]           cm_pc_i,
  input  logic                  bpd_rt_we_i,
  input  logic                  bpd_rt_brdir_i,
  input  logic                  bpd_ch_we_i,
  input  logic                  bpd_ch_brdir_i,
  input  logic [GHR_WIDTH-1:0]  bpd_rt_ghr_i,
  input  logic                  bpd_sp_we_i,
  input  logic                  bpd_sp_brdir_i,
  input  logic                  bpd_flush_i,
  output logic                  bpd_ready_o,
  output logic                  bpd_pht_choice_f1,
  output logic [HIST_WIDTH-1:0] bpd_bht_lochist_f1,
  output logic [GHR_WIDTH-1:0]  bpd_ghr_f1
);

  localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);
  localparam int CH_IDX_W  = $clog2(CH_ENTRIES);
  localparam int SWEEP_N   = (BHT_ENTRIES > CH_ENTRIES) ? BHT_ENTRIES : CH_ENTRIES;
  localparam int SWEEP_W   = $clog2(SWEEP_N);
  localparam logic [SWEEP_W-1:0] SWEEP_LAST = SWEEP_W'(SWEEP_N - 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [SWEEP_W-1:0]    sweep_q, sweep_d;
  logic [GHR_WIDTH-1:0]  ghr_q, ghr_d;
  logic                  choice_f1_q, choice_f1_d;
  logic [HIST_WIDTH-1:0] lochist_f1_q, lochist_f1_d;
  logic [GHR_WIDTH-1:0]  ghr_f1_q, ghr_f1_d;

  logic [HIST_WIDTH-1:0]   bht_mem [BHT_ENTRIES];
  logic [SATCNT_WIDTH-1:0] ch_mem  [CH_ENTRIES];

  logic                    run;
  logic [BHT_IDX_W-1:0]    bht_rd_idx, bht_rt_idx;
  logic [CH_IDX_W-1:0]     ch_rd_base, ch_wr_base, ch_rd_idx, ch_wr_idx;
  logic [CH_IDX_W-1:0]     ghr_sp_idx, ghr_rt_idx;
  logic                    bht_we, ch_we;
  logic [BHT_IDX_W-1:0]    bht_wa;
  logic [CH_IDX_W-1:0]     ch_wa;
  logic [HIST_WIDTH-1:0]   bht_wd;
  logic [SATCNT_WIDTH-1:0] ch_wd, ch_cur;
  logic                    unused_pc_bits;

  assign unused_pc_bits = ^{sp_pc_i, cm_pc_i};

  assign run        = (state_q == ST_RUN);
  assign bht_rd_idx = sp_pc_i[BHT_IDX_W+1:2];
  assign bht_rt_idx = cm_pc_i[BHT_IDX_W+1:2];
  assign ch_rd_base = sp_pc_i[CH_IDX_W+1:2];
  assign ch_wr_base = cm_pc_i[CH_IDX_W+1:2];

  // Histories are fitted to the choice index width before hashing.
  if (GHR_WIDTH >= CH_IDX_W) begin : g_ghr_trunc
    assign ghr_sp_idx = ghr_q[CH_IDX_W-1:0];
    assign ghr_rt_idx = bpd_rt_ghr_i[CH_IDX_W-1:0];
  end else begin : g_ghr_zext
    assign ghr_sp_idx = {{(CH_IDX_W-GHR_WIDTH){1'b0}}, ghr_q};
    assign ghr_rt_idx = {{(CH_IDX_W-GHR_WIDTH){1'b0}}, bpd_rt_ghr_i};
  end

  assign ch_rd_idx = (CH_INDEX_MODE == 1) ? (ch_rd_base ^ ghr_sp_idx) : ch_rd_base;
  assign ch_wr_idx = (CH_INDEX_MODE == 1) ? (ch_wr_base ^ ghr_rt_idx) : ch_wr_base;
  assign ch_cur    = ch_mem[ch_wr_idx];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    ghr_d        = ghr_q;
    choice_f1_d  = choice_f1_q;
    lochist_f1_d = lochist_f1_q;
    ghr_f1_d     = ghr_f1_q;
    bht_we       = 1'b0;
    bht_wa       = bht_rt_idx;
    bht_wd       = {bht_mem[bht_rt_idx][HIST_WIDTH-2:0], bpd_rt_brdir_i};
    ch_we        = 1'b0;
    ch_wa        = ch_wr_idx;
    ch_wd        = ch_cur;

    if (!run) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == SWEEP_LAST) state_d = ST_RUN;
      bht_we = (32'(sweep_q) < BHT_ENTRIES);
      bht_wa = sweep_q[BHT_IDX_W-1:0];
      bht_wd = '0;
      ch_we  = (32'(sweep_q) < CH_ENTRIES);
      ch_wa  = sweep_q[CH_IDX_W-1:0];
      ch_wd  = SATCNT_INIT;
    end else begin
      bht_we = bpd_rt_we_i;
      ch_we  = bpd_rt_we_i & bpd_ch_we_i;
      if (bpd_rt_brdir_i ^ bpd_ch_brdir_i) begin
        if (ch_cur != '1) ch_wd = ch_cur + 1'b1;
      end else begin
        if (ch_cur != '0) ch_wd = ch_cur - 1'b1;
      end

      if (bpd_flush_i)      ghr_d = bpd_rt_ghr_i;
      else if (bpd_sp_we_i) ghr_d = {ghr_q[GHR_WIDTH-2:0], bpd_sp_brdir_i};

      if (load_fetch_i) begin
        choice_f1_d  = ch_mem[ch_rd_idx][SATCNT_WIDTH-1];
        lochist_f1_d = bht_mem[bht_rd_idx];
        ghr_f1_d     = ghr_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      sweep_q      <= '0;
      ghr_q        <= '0;
      choice_f1_q  <= 1'b0;
      lochist_f1_q <= '0;
      ghr_f1_q     <= '0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      ghr_q        <= ghr_d;
      choice_f1_q  <= choice_f1_d;
      lochist_f1_q <= lochist_f1_d;
      ghr_f1_q     <= ghr_f1_d;
    end
  end

  // NOTE: the tables carry no reset so they map onto RAM; the INIT sweep gives them known contents.
  always_ff @(posedge clock) begin
    if (bht_we) bht_mem[bht_wa] <= bht_wd;
    if (ch_we)  ch_mem[ch_wa]   <= ch_wd;
  end

  assign bpd_ready_o        = run;
  assign bpd_pht_choice_f1  = choice_f1_q;
  assign bpd_bht_lochist_f1 = lochist_f1_q;
  assign bpd_ghr_f1         = ghr_f1_q;

endmodule

// File: tb/tb_bpd_stage1_param.sv
// Scoreboarded bench for bpd_stage1_param: one PC-indexed and one gshare-indexed instance,
// directed vectors with expected f1 values queued at issue and checked by a monitor.
module tb_bpd_stage1_param;

  typedef struct {
    logic        ch;
    logic [9:0]  hist;
    logic [11:0] ghr;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic        load0, rt_we0, rt_dir0, ch_we0, ch_dir0, sp_we0, sp_dir0, flush0;
  logic [63:0] sp_pc0, cm_pc0;
  logic [11:0] rt_ghr0;
  logic        ready0, choice0;
  logic [9:0]  hist0;
  logic [11:0] ghr0;

  logic        load1, rt_we1, rt_dir1, ch_we1, ch_dir1, sp_we1, sp_dir1, flush1;
  logic [63:0] sp_pc1, cm_pc1;
  logic [11:0] rt_ghr1;
  logic        ready1, choice1;
  logic [9:0]  hist1;
  logic [11:0] ghr1;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic fire0 = 1'b0;
  logic fire1 = 1'b0;

  bpd_stage1_param u_dut0 (
    .clock(clock), .reset_n(reset_n), .load_fetch_i(load0),
    .sp_pc_i(sp_pc0), .cm_pc_i(cm_pc0),
    .bpd_rt_we_i(rt_we0), .bpd_rt_brdir_i(rt_dir0),
    .bpd_ch_we_i(ch_we0), .bpd_ch_brdir_i(ch_dir0),
    .bpd_rt_ghr_i(rt_ghr0), .bpd_sp_we_i(sp_we0), .bpd_sp_brdir_i(sp_dir0),
    .bpd_flush_i(flush0), .bpd_ready_o(ready0), .bpd_pht_choice_f1(choice0),
    .bpd_bht_lochist_f1(hist0), .bpd_ghr_f1(ghr0)
  );

  bpd_stage1_param #(.CH_INDEX_MODE(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .load_fetch_i(load1),
    .sp_pc_i(sp_pc1), .cm_pc_i(cm_pc1),
    .bpd_rt_we_i(rt_we1), .bpd_rt_brdir_i(rt_dir1),
    .bpd_ch_we_i(ch_we1), .bpd_ch_brdir_i(ch_dir1),
    .bpd_rt_ghr_i(rt_ghr1), .bpd_sp_we_i(sp_we1), .bpd_sp_brdir_i(sp_dir1),
    .bpd_flush_i(flush1), .bpd_ready_o(ready1), .bpd_pht_choice_f1(choice1),
    .bpd_bht_lochist_f1(hist1), .bpd_ghr_f1(ghr1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // A load issued before edge N is visible on the f1 outputs at the negedge after edge N.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        fire0 = 1'b0;
        fire1 = 1'b0;
      end else begin
        if (fire0) begin
          if (q0.size() == 0) check("dut0_unexpected_output", 32'd1, 32'd0);
          else begin
            e = q0.pop_front();
            check("dut0_f1", 32'({choice0, hist0, ghr0}), 32'({e.ch, e.hist, e.ghr}));
          end
        end
        if (fire1) begin
          if (q1.size() == 0) check("dut1_unexpected_output", 32'd1, 32'd0);
          else begin
            e = q1.pop_front();
            check("dut1_f1", 32'({choice1, hist1, ghr1}), 32'({e.ch, e.hist, e.ghr}));
          end
        end
        fire0 = load0 & ready0;
        fire1 = load1 & ready1;
      end
    end
  end

  task automatic read0(input logic [63:0] pc, input logic ch, input logic [9:0] h, input logic [11:0] g);
    q0.push_back('{ch, h, g});
    sp_pc0 = pc;
    load0  = 1'b1;
    cycle();
    load0  = 1'b0;
  endtask

  task automatic read1(input logic [63:0] pc, input logic ch, input logic [9:0] h, input logic [11:0] g);
    q1.push_back('{ch, h, g});
    sp_pc1 = pc;
    load1  = 1'b1;
    cycle();
    load1  = 1'b0;
  endtask

  task automatic retire0(input logic [63:0] pc, input logic dir, input logic chwe, input logic chdir);
    cm_pc0 = pc; rt_dir0 = dir; ch_we0 = chwe; ch_dir0 = chdir; rt_we0 = 1'b1;
    cycle();
    rt_we0 = 1'b0; ch_we0 = 1'b0;
  endtask

  task automatic spec0(input logic dir);
    sp_we0 = 1'b1; sp_dir0 = dir;
    cycle();
    sp_we0 = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int cnt = 0;
    while (!(ready0 && ready1) && cnt < 5000) begin
      cycle();
      cnt++;
    end
    check(name, 32'(cnt), 32'd4096);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    {load0, rt_we0, rt_dir0, ch_we0, ch_dir0, sp_we0, sp_dir0, flush0} = '0;
    {load1, rt_we1, rt_dir1, ch_we1, ch_dir1, sp_we1, sp_dir1, flush1} = '0;
    sp_pc0 = '0; cm_pc0 = '0; rt_ghr0 = '0;
    sp_pc1 = '0; cm_pc1 = '0; rt_ghr1 = '0;
    repeat (3) cycle();
    check("reset_ready", 32'(ready0), 32'd0);
    check("reset_f1", 32'({choice0, hist0, ghr0}), 32'd0);

    // Everything driven during the sweep must be ignored.
    reset_n = 1'b1;
    load0 = 1'b1; sp_pc0 = 64'h100;
    rt_we0 = 1'b1; rt_dir0 = 1'b1; cm_pc0 = 64'h100;
    sp_we0 = 1'b1; sp_dir0 = 1'b1;
    flush0 = 1'b1; rt_ghr0 = 12'hFFF;
    wait_ready("init_sweep_cycles");
    {load0, rt_we0, rt_dir0, sp_we0, sp_dir0, flush0} = '0;
    check("init_f1_untouched", 32'({choice0, hist0, ghr0}), 32'd0);

    read0(64'h100, 1'b1, 10'h000, 12'h000);
    read0(64'h2468, 1'b1, 10'h000, 12'h000);

    retire0(64'h100, 1'b1, 1'b0, 1'b0);
    retire0(64'h100, 1'b1, 1'b0, 1'b0);
    retire0(64'h100, 1'b0, 1'b0, 1'b0);
    read0(64'h100, 1'b1, 10'h006, 12'h000);

    repeat (4) retire0(64'h100, 1'b1, 1'b1, 1'b0);
    read0(64'h100, 1'b1, 10'h06F, 12'h000);
    retire0(64'h100, 1'b0, 1'b1, 1'b0);
    read0(64'h100, 1'b1, 10'h0DE, 12'h000);
    repeat (2) retire0(64'h100, 1'b0, 1'b1, 1'b0);
    read0(64'h100, 1'b0, 10'h378, 12'h000);
    retire0(64'h100, 1'b1, 1'b1, 1'b1);
    read0(64'h100, 1'b0, 10'h2F1, 12'h000);

    repeat (3) spec0(1'b1);
    read0(64'h100, 1'b0, 10'h2F1, 12'h007);
    flush0 = 1'b1; rt_ghr0 = 12'h0A5; sp_we0 = 1'b1; sp_dir0 = 1'b1;
    cycle();
    flush0 = 1'b0; sp_we0 = 1'b0;
    read0(64'h100, 1'b0, 10'h2F1, 12'h0A5);
    spec0(1'b0);
    read0(64'h2468, 1'b1, 10'h000, 12'h14A);
    cycle();

    retire0(64'h2468, 1'b1, 1'b1, 1'b1);
    spec0(1'b1);
    check("hold_f1", 32'({choice0, hist0, ghr0}), 32'({1'b1, 10'h000, 12'h14A}));
    read0(64'h2468, 1'b0, 10'h001, 12'h295);

    // Gshare instance: entry (0x8>>2)^3 = 1 is trained, entry 2 is left at its init value.
    cm_pc1 = 64'h8; rt_ghr1 = 12'h003; rt_we1 = 1'b1; ch_we1 = 1'b1;
    rt_dir1 = 1'b0; ch_dir1 = 1'b0; flush1 = 1'b1;
    cycle();
    {rt_we1, ch_we1, flush1} = '0;
    read1(64'h8, 1'b0, 10'h000, 12'h003);
    flush1 = 1'b1; rt_ghr1 = 12'h000;
    cycle();
    flush1 = 1'b0;
    read1(64'h8, 1'b1, 10'h000, 12'h000);
    rt_ghr1 = 12'h003; flush1 = 1'b1; rt_we1 = 1'b1; ch_we1 = 1'b1;
    rt_dir1 = 1'b1; ch_dir1 = 1'b0;
    cycle();
    {rt_we1, ch_we1, flush1} = '0;
    read1(64'h8, 1'b1, 10'h001, 12'h003);
    cycle();

    reset_n = 1'b0;
    #1;
    check("run_reset_ready", 32'(ready0), 32'd0);
    check("run_reset_f1", 32'({choice0, hist0, ghr0}), 32'd0);
    check("run_reset_f1_dut1", 32'({choice1, hist1, ghr1}), 32'd0);
    cycle();
    reset_n = 1'b1;
    wait_ready("resweep_cycles");
    read0(64'h100, 1'b1, 10'h000, 12'h000);
    cycle();
    cycle();

    check("dut0_queue_drained", 32'(q0.size()), 32'd0);
    check("dut1_queue_drained", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
